// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared single-port synchronous memory between an instruction fetch
// port and a load/store port. A fetch that keeps losing is eventually forced to win.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no access accepted last cycle, no response due
// RSP_IF | fetch accepted last cycle, memory read data is on mem_rdata
// RSP_D  | load/store accepted last cycle, respond on the data port
module mem_port_arbiter #(
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             if_req_valid,
    input  logic [31:0]      if_req_addr,
    output logic             if_req_ready,
    input  logic             if_flush,
    output logic             if_rsp_valid,
    output logic [31:0]      if_rsp_data,

    input  logic             d_req_valid,
    input  logic             d_req_we,
    input  logic [31:0]      d_req_addr,
    input  logic [31:0]      d_req_wdata,
    input  logic [3:0]       d_req_wstrb,
    output logic             d_req_ready,
    output logic             d_rsp_valid,
    output logic [31:0]      d_rsp_rdata,

    output logic             mem_en,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata,

    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSP_IF = 2'd1,
        RSP_D  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt;
    logic          force_if;
    logic          kill_q;
    logic          we_q;
    logic          if_acc;
    logic          d_acc;

    // Readies are held low during reset so nothing is accepted while rst_n is asserted.
    assign force_if     = (starve_cnt >= STARVE_LIM);
    assign if_req_ready = rst_n && (!d_req_valid || force_if);
    assign d_req_ready  = rst_n && !(if_req_valid && force_if);
    assign if_acc       = if_req_valid && if_req_ready;
    assign d_acc        = d_req_valid && d_req_ready;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        if (if_acc) begin
            mem_en   = 1'b1;
            mem_addr = if_req_addr;
        end else if (d_acc) begin
            mem_en    = 1'b1;
            mem_we    = d_req_we;
            mem_addr  = d_req_addr;
            mem_wdata = d_req_wdata;
            mem_wstrb = d_req_wstrb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (if_acc) begin
            state_nxt = RSP_IF;
        end else if (d_acc) begin
            state_nxt = RSP_D;
        end
    end

    always_comb begin
        if_rsp_valid = (state == RSP_IF) && !kill_q && !if_flush;
        if_rsp_data  = mem_rdata;
        d_rsp_valid  = (state == RSP_D);
        d_rsp_rdata  = (state == RSP_D && !we_q) ? mem_rdata : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            kill_q     <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            if (if_acc) begin
                starve_cnt <= '0;
            end else if (if_req_valid && !force_if) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
            // A flush in the acceptance cycle kills the response that arrives next cycle.
            if (if_acc) begin
                kill_q <= if_flush;
            end else if (state == RSP_IF) begin
                kill_q <= 1'b0;
            end
            if (d_acc) begin
                we_q <= d_req_we;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (if_req_valid && d_req_valid && conflict_cnt != {CNT_W{1'b1}}) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of grants,
// responses and a reference memory image.
module tb_mem_port_arbiter;

    localparam int SM = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req_valid;
    logic [31:0]   if_req_addr;
    logic          if_req_ready;
    logic          if_flush;
    logic          if_rsp_valid;
    logic [31:0]   if_rsp_data;
    logic          d_req_valid;
    logic          d_req_we;
    logic [31:0]   d_req_addr;
    logic [31:0]   d_req_wdata;
    logic [3:0]    d_req_wstrb;
    logic          d_req_ready;
    logic          d_rsp_valid;
    logic [31:0]   d_rsp_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_rdata;
    logic [CW-1:0] conflict_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_MAX(SM), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    // Memory environment driven only by the DUT's mem_* outputs.
    logic [31:0] env_mem [1024];
    always @(posedge clk) begin
        logic [31:0] w;
        if (mem_en) begin
            if (mem_we) begin
                w = env_mem[mem_addr[11:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                env_mem[mem_addr[11:2]] <= w;
            end else begin
                mem_rdata <= env_mem[mem_addr[11:2]];
            end
        end
    end

    // Reference model: memory image plus the single outstanding response.
    logic [31:0] ref_mem [1024];
    int          m_starve;
    int          m_pend;       // 0 none, 1 fetch, 2 data
    bit          m_kill;
    bit          m_we;
    logic [31:0] m_data;
    int          m_conf;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_starve = 0;
        m_pend   = 0;
        m_kill   = 0;
        m_we     = 0;
        m_conf   = 0;
    endtask

    task automatic step(input bit iv, input logic [31:0] ia, input bit fl,
                        input bit dv, input bit dwe, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [3:0] dst);
        bit          frc, ig, dg, ifv;
        logic [31:0] w;
        @(negedge clk);
        if_req_valid = iv;  if_req_addr = ia;  if_flush = fl;
        d_req_valid  = dv;  d_req_we = dwe;    d_req_addr = da;
        d_req_wdata  = dwd; d_req_wstrb = dst;
        #1;
        ifv = (m_pend == 1) && !m_kill && !fl;
        chk("if_rsp_valid", 32'(if_rsp_valid), 32'(ifv));
        if (ifv) chk("if_rsp_data", if_rsp_data, m_data);
        chk("d_rsp_valid", 32'(d_rsp_valid), 32'(m_pend == 2));
        if (m_pend == 2) chk("d_rsp_rdata", d_rsp_rdata, m_we ? 32'd0 : m_data);
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));

        frc = (m_starve >= SM);
        chk("if_req_ready", 32'(if_req_ready), 32'(!dv || frc));
        chk("d_req_ready", 32'(d_req_ready), 32'(!(iv && frc)));
        ig = iv && (!dv || frc);
        dg = dv && !ig;
        chk("mem_en", 32'(mem_en), 32'(ig || dg));
        if (ig) begin
            chk("mem_addr_if", mem_addr, ia);
            chk("mem_we_if", 32'(mem_we), 32'd0);
            chk("mem_wstrb_if", 32'(mem_wstrb), 32'd0);
        end else if (dg) begin
            chk("mem_addr_d", mem_addr, da);
            chk("mem_we_d", 32'(mem_we), 32'(dwe));
            chk("mem_wdata_d", mem_wdata, dwd);
            chk("mem_wstrb_d", 32'(mem_wstrb), 32'(dst));
        end else begin
            chk("mem_we_idle", 32'(mem_we), 32'd0);
            chk("mem_wstrb_idle", 32'(mem_wstrb), 32'd0);
        end

        if (ig) m_starve = 0;
        else if (iv) m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
        if (iv && dv && m_conf < (1 << CW) - 1) m_conf++;
        m_pend = ig ? 1 : (dg ? 2 : 0);
        m_kill = ig && fl;
        m_we   = dg && dwe;
        if (ig) m_data = ref_mem[ia[11:2]];
        if (dg) begin
            if (dwe) begin
                w = ref_mem[da[11:2]];
                for (int b = 0; b < 4; b++)
                    if (dst[b]) w[8*b +: 8] = dwd[8*b +: 8];
                ref_mem[da[11:2]] = w;
            end else begin
                m_data = ref_mem[da[11:2]];
            end
        end
    endtask

    task automatic idle();
        step(0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
    endtask

    // Assert reset with both requesters active; everything must read back at reset values.
    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        if_req_valid = 1'b1; d_req_valid = 1'b1; d_req_we = 1'b1; d_req_wstrb = 4'hF;
        #1;
        chk("rst_if_req_ready", 32'(if_req_ready), 32'd0);
        chk("rst_d_req_ready", 32'(d_req_ready), 32'd0);
        chk("rst_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
        chk("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        if_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0; d_req_wstrb = 4'h0;
        model_reset();
    endtask

    function automatic logic [31:0] raddr();
        return 32'(($urandom_range(0, 255)) << 2);
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        rst_n = 1'b0;
        if_req_valid = 0; if_req_addr = 0; if_flush = 0;
        d_req_valid = 0; d_req_we = 0; d_req_addr = 0; d_req_wdata = 0; d_req_wstrb = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_pulse();

        // Six cycles of contention: D, D, D, forced IF, D, D.
        for (int c = 0; c < 6; c++)
            step(1, raddr(), 0, 1, 0, raddr(), 32'd0, 4'd0);
        idle();
        chk("conflict_after_6", 32'(conflict_cnt), 32'd6);

        // Plain fetch with known memory content.
        env_mem[32'h100 >> 2] = 32'h00100393;
        ref_mem[32'h100 >> 2] = 32'h00100393;
        step(1, 32'h100, 0, 0, 0, 32'd0, 32'd0, 4'd0);
        idle();
        chk("fetch_0x100_data", if_rsp_data, 32'h00100393);

        // Store then load back.
        step(0, 32'd0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 4'hF);
        step(0, 32'd0, 0, 1, 0, 32'h200, 32'd0, 4'd0);
        idle();
        chk("load_0x200", d_rsp_rdata, 32'hDEADBEEF);

        // Flush on acceptance, then flush in the response cycle.
        step(1, 32'h40, 1, 0, 0, 32'd0, 32'd0, 4'd0);
        idle();
        step(1, 32'h44, 0, 0, 0, 32'd0, 32'd0, 4'd0);
        step(0, 32'd0, 1, 0, 0, 32'd0, 32'd0, 4'd0);
        idle();

        // Back-to-back fetches.
        step(1, 32'h0, 0, 0, 0, 32'd0, 32'd0, 4'd0);
        step(1, 32'h4, 0, 0, 0, 32'd0, 32'd0, 4'd0);
        step(1, 32'h8, 0, 0, 0, 32'd0, 32'd0, 4'd0);
        idle();

        // Reset while a data response is due; nothing may surface afterwards.
        step(1, raddr(), 0, 1, 0, raddr(), 32'd0, 4'd0);
        step(0, 32'd0, 0, 1, 0, raddr(), 32'd0, 4'd0);
        reset_pulse();
        idle();
        idle();

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_pulse();
            end else begin
                step($urandom_range(0, 9) < 7, raddr(), $urandom_range(0, 9) < 2,
                     $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, raddr(),
                     $urandom, 4'($urandom_range(0, 15)));
            end
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
